// File: rtl/iob_ethmac_mem_arbiter.sv
// Round-robin arbiter sharing one IOb memory port between the MAC DMA (port 0) and CPU (port 1).
// One transaction in flight; a watchdog force-completes hung accesses with zero data.
module iob_ethmac_mem_arbiter #(
    parameter int MEM_ADDR_W = 32,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  s0_valid,
    input  logic [MEM_ADDR_W-1:0] s0_addr,
    input  logic [DATA_W-1:0]     s0_wdata,
    input  logic [DATA_W/8-1:0]   s0_wstrb,
    output logic [DATA_W-1:0]     s0_rdata,
    output logic                  s0_ready,
    input  logic                  s1_valid,
    input  logic [MEM_ADDR_W-1:0] s1_addr,
    input  logic [DATA_W-1:0]     s1_wdata,
    input  logic [DATA_W/8-1:0]   s1_wstrb,
    output logic [DATA_W-1:0]     s1_rdata,
    output logic                  s1_ready,
    output logic                  mem_valid,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ready,
    output logic                  grant_o,
    output logic                  busy_o,
    output logic                  timeout_o
);

    // state  | meaning
    // S_IDLE | no transaction in flight, arbitrating
    // S_WAIT | mem_* driven, waiting for mem_ready or watchdog expiry

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_TC = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t           state;
    logic             last_grant;
    logic [CNT_W-1:0] cnt;
    logic             pick;
    logic             forced;
    logic             done;

    // On a tie the port that did not win last time goes next.
    always_comb begin
        pick = (s0_valid && s1_valid) ? ~last_grant : s1_valid;
    end

    always_comb begin
        forced    = (TIMEOUT != 0) && busy_o && !mem_ready && (cnt == CNT_TC);
        done      = busy_o && (mem_ready || forced);
        timeout_o = forced;
        s0_ready  = done && !grant_o;
        s1_ready  = done && grant_o;
        s0_rdata  = (busy_o && !grant_o && mem_ready) ? mem_rdata : '0;
        s1_rdata  = (busy_o && grant_o && mem_ready) ? mem_rdata : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            mem_valid  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            grant_o    <= 1'b0;
            busy_o     <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (s0_valid || s1_valid) begin
                        state      <= S_WAIT;
                        mem_valid  <= 1'b1;
                        busy_o     <= 1'b1;
                        grant_o    <= pick;
                        last_grant <= pick;
                        cnt        <= '0;
                        mem_addr   <= pick ? s1_addr  : s0_addr;
                        mem_wdata  <= pick ? s1_wdata : s0_wdata;
                        mem_wstrb  <= pick ? s1_wstrb : s0_wstrb;
                    end
                end
                S_WAIT: begin
                    if (mem_ready || forced) begin
                        state     <= S_IDLE;
                        mem_valid <= 1'b0;
                        busy_o    <= 1'b0;
                    end else if (cnt != '1) begin
                        // saturate rather than wrap when the watchdog is disabled
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule
